// File: rtl/multicycle_stage_sequencer_pkg.sv
// Shared stage encodings, enable bundle and width helpers
// for the multi-cycle stage sequencer.
package multicycle_stage_sequencer_pkg;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IF       = 4'd1,
        S_IF_WAIT  = 4'd2,
        S_ID       = 4'd3,
        S_EX       = 4'd4,
        S_MEM      = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_WB       = 4'd7,
        S_HALT     = 4'd8
    } stage_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
        logic ram;
        logic rf;
        logic srn;
    } en_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/multicycle_stage_sequencer_wait_timer.sv
// Shared wait-state timer: minimum latency compare, busy
// extension and stall watchdog for IF_WAIT / MEM_WAIT.
module stage_wait_timer
    import multicycle_stage_sequencer_pkg::*;
#(
    parameter int WAIT_W    = 1,
    parameter int STALL_MAX = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              busy,
    input  logic [WAIT_W-1:0] limit,
    output logic              done,
    output logic              trip
);

    localparam int STALL_W = cnt_width(STALL_MAX);

    logic [WAIT_W-1:0]  wait_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               at_lim;
    logic               stalled;

    always_comb begin
        at_lim  = (wait_cnt >= limit);
        done    = active && at_lim && !busy;
        stalled = active && at_lim && busy;
        trip    = (STALL_MAX != 0) && stalled
                  && (stall_cnt == STALL_W'(STALL_MAX));
    end

    // Both counters saturate; only the compares matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else if (!active) begin
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (!at_lim)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (stalled && (stall_cnt != STALL_W'(STALL_MAX)))
                stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Multi-cycle stage sequencer: walks one instruction through
// IF..WB and drives the per-stage datapath write enables.
module multicycle_stage_sequencer
    import multicycle_stage_sequencer_pkg::*;
#(
    parameter int IF_LAT    = 2,
    parameter int MEM_LAT   = 2,
    parameter int STALL_MAX = 255,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             mem_op,
    input  logic             mem_we,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_wren,
    output logic             if_id_wren,
    output logic             id_ex_wren,
    output logic             ex_mem_wren,
    output logic             mem_wb_wren,
    output logic             ram_wren,
    output logic             reg_wren,
    output logic             stage_reset_n,
    output logic [3:0]       stage,
    output logic             halted,
    output logic             stall_fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_MAX = max_int(IF_LAT, MEM_LAT) - 1;
    localparam int WAIT_W   = cnt_width(WAIT_MAX);

    stage_e            state;
    stage_e            next;
    logic              mem_op_q;
    logic              in_wait;
    logic              busy;
    logic              done;
    logic              trip;
    logic [WAIT_W-1:0] limit;
    en_t               en;

    // A data-less MEM_WAIT finishes in one cycle and ignores busy.
    always_comb begin
        in_wait = (state == S_IF_WAIT) || (state == S_MEM_WAIT);
        busy    = 1'b0;
        limit   = '0;
        if (state == S_IF_WAIT) begin
            busy  = imem_busy;
            limit = WAIT_W'(IF_LAT - 1);
        end else if (state == S_MEM_WAIT && mem_op_q) begin
            busy  = dmem_busy;
            limit = WAIT_W'(MEM_LAT - 1);
        end
    end

    stage_wait_timer #(
        .WAIT_W   (WAIT_W),
        .STALL_MAX(STALL_MAX)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .active (in_wait),
        .busy   (busy),
        .limit  (limit),
        .done   (done),
        .trip   (trip)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_INIT;
        else
            state <= next;
    end

    always_comb begin
        next = S_INIT;
        case (state)
            S_INIT:     next = S_IF;
            S_IF:       next = S_IF_WAIT;
            S_IF_WAIT:  next = trip ? S_HALT :
                               done ? S_ID : S_IF_WAIT;
            S_ID:       next = S_EX;
            S_EX:       next = S_MEM;
            S_MEM:      next = S_MEM_WAIT;
            S_MEM_WAIT: next = trip ? S_HALT :
                               done ? S_WB : S_MEM_WAIT;
            S_WB:       next = halt_req ? S_HALT : S_IF;
            S_HALT:     next = (resume && !stall_fault) ?
                               S_IF : S_HALT;
            default:    next = S_INIT;
        endcase
    end

    always_comb begin
        en = '0;
        case (state)
            S_IF:       en.srn = 1'b1;
            S_IF_WAIT: begin
                en.srn   = 1'b1;
                en.if_id = done;
            end
            S_ID: begin
                en.srn   = 1'b1;
                en.id_ex = 1'b1;
            end
            S_EX: begin
                en.srn    = 1'b1;
                en.ex_mem = 1'b1;
            end
            S_MEM: begin
                en.srn = 1'b1;
                en.pc  = 1'b1;
                en.ram = mem_we;
            end
            S_MEM_WAIT: begin
                en.srn    = 1'b1;
                en.mem_wb = done;
            end
            S_WB:       en.rf = 1'b1;
            default:    en = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_op_q    <= 1'b0;
            retired     <= '0;
            stall_fault <= 1'b0;
        end else begin
            if (state == S_EX)
                mem_op_q <= mem_op;
            if (state == S_WB)
                retired <= retired + CNT_W'(1);
            if (trip)
                stall_fault <= 1'b1;
        end
    end

    assign pc_wren       = en.pc;
    assign if_id_wren    = en.if_id;
    assign id_ex_wren    = en.id_ex;
    assign ex_mem_wren   = en.ex_mem;
    assign mem_wb_wren   = en.mem_wb;
    assign ram_wren      = en.ram;
    assign reg_wren      = en.rf;
    assign stage_reset_n = en.srn;
    assign stage         = state;
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_stage_sequencer;

    localparam int IF_LAT    = 2;
    localparam int MEM_LAT   = 2;
    localparam int STALL_MAX = 4;
    localparam int CNT_W     = 4;

    localparam logic [3:0] S_INIT = 4'd0;
    localparam logic [3:0] S_IF   = 4'd1;
    localparam logic [3:0] S_IFW  = 4'd2;
    localparam logic [3:0] S_ID   = 4'd3;
    localparam logic [3:0] S_EX   = 4'd4;
    localparam logic [3:0] S_MEM  = 4'd5;
    localparam logic [3:0] S_MEMW = 4'd6;
    localparam logic [3:0] S_WB   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    typedef struct packed {
        logic [3:0]       stage;
        logic [6:0]       en;
        logic             srn;
        logic             halted;
        logic             fault;
        logic [CNT_W-1:0] retired;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, imem_busy, dmem_busy, mem_op, mem_we;
    logic halt_req, resume;
    logic pc_wren, if_id_wren, id_ex_wren, ex_mem_wren;
    logic mem_wb_wren, ram_wren, reg_wren, stage_reset_n;
    logic [3:0] stage;
    logic halted, stall_fault;
    logic [CNT_W-1:0] retired;

    exp_t scb[$];
    event probe;
    int tests = 0;
    int fails = 0;
    int pc_cnt = 0;
    int cyc_no = 0;
    logic [CNT_W-1:0] exp_ret;
    logic exp_fault;

    multicycle_stage_sequencer #(
        .IF_LAT   (IF_LAT),
        .MEM_LAT  (MEM_LAT),
        .STALL_MAX(STALL_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .mem_op       (mem_op),
        .mem_we       (mem_we),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_wren      (pc_wren),
        .if_id_wren   (if_id_wren),
        .id_ex_wren   (id_ex_wren),
        .ex_mem_wren  (ex_mem_wren),
        .mem_wb_wren  (mem_wb_wren),
        .ram_wren     (ram_wren),
        .reg_wren     (reg_wren),
        .stage_reset_n(stage_reset_n),
        .stage        (stage),
        .halted       (halted),
        .stall_fault  (stall_fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc_no, act, req);
        end
    endtask

    // Monitor: compares every expectation the stimulus queued.
    initial begin
        exp_t e;
        logic [6:0] act_en;
        forever begin
            @(negedge clk or probe);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                act_en = {pc_wren, if_id_wren, id_ex_wren,
                          ex_mem_wren, mem_wb_wren, ram_wren,
                          reg_wren};
                chk("stage", int'(stage), int'(e.stage));
                chk("enables", int'(act_en), int'(e.en));
                chk("stage_reset_n", int'(stage_reset_n),
                    int'(e.srn));
                chk("halted", int'(halted), int'(e.halted));
                chk("stall_fault", int'(stall_fault),
                    int'(e.fault));
                chk("retired", int'(retired), int'(e.retired));
                if (pc_wren)
                    pc_cnt++;
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] st,
                                input logic [6:0] en,
                                input logic srn);
        exp_t e;
        e.stage   = st;
        e.en      = en;
        e.srn     = srn;
        e.halted  = (st == S_HALT);
        e.fault   = exp_fault;
        e.retired = exp_ret;
        return e;
    endfunction

    task automatic cyc(input logic [3:0] st, input logic [6:0] en,
                       input logic srn);
        scb.push_back(mk(st, en, srn));
        @(posedge clk);
        #1;
        cyc_no++;
        if (st == S_WB)
            exp_ret = exp_ret + 1'b1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        imem_busy = 1'b0;
        dmem_busy = 1'b0;
        mem_op    = 1'b0;
        mem_we    = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        exp_ret   = '0;
        exp_fault = 1'b0;
        cyc(S_INIT, 7'b0, 1'b0);
        cyc(S_INIT, 7'b0, 1'b0);
        reset_n = 1'b1;
        cyc(S_INIT, 7'b0, 1'b0);
    endtask

    // ib/db: leading busy cycles in IF_WAIT / MEM_WAIT.
    task automatic instr(input int ib, input int db, input bit mop,
                         input bit we, input bit hreq);
        int n;
        mem_op = mop;
        mem_we = we;
        cyc(S_IF, 7'b0, 1'b1);
        n = (ib > IF_LAT - 1) ? ib : IF_LAT - 1;
        for (int k = 0; k <= n; k++) begin
            imem_busy = (k < ib);
            cyc(S_IFW, (k == n) ? 7'b0100000 : 7'b0, 1'b1);
        end
        imem_busy = 1'b0;
        cyc(S_ID, 7'b0010000, 1'b1);
        cyc(S_EX, 7'b0001000, 1'b1);
        cyc(S_MEM, {1'b1, 4'b0, we, 1'b0}, 1'b1);
        n = mop ? ((db > MEM_LAT - 1) ? db : MEM_LAT - 1) : 0;
        for (int k = 0; k <= n; k++) begin
            dmem_busy = (k < db);
            cyc(S_MEMW, (k == n) ? 7'b0000100 : 7'b0, 1'b1);
        end
        dmem_busy = 1'b0;
        halt_req  = hreq;
        resume    = hreq;
        cyc(S_WB, 7'b0000001, 1'b0);
        halt_req = 1'b0;
        resume   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc_no);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        base = pc_cnt;
        instr(0, 0, 0, 0, 0);
        instr(0, 0, 0, 0, 0);
        instr(0, 3, 1, 1, 0);
        instr(0, 2, 0, 0, 0);
        instr(5, 0, 0, 0, 0);
        instr(0, 0, 0, 0, 1);
        repeat (5) cyc(S_HALT, 7'b0, 1'b0);
        resume = 1'b1;
        cyc(S_HALT, 7'b0, 1'b0);
        resume = 1'b0;
        for (int i = 0; i < 10; i++)
            instr(0, 0, 0, 0, 0);
        chk("pc_wren_count", pc_cnt - base, 16);
        cyc(S_IF, 7'b0, 1'b1);
        imem_busy = 1'b1;
        repeat (IF_LAT + STALL_MAX) cyc(S_IFW, 7'b0, 1'b1);
        exp_fault = 1'b1;
        resume    = 1'b1;
        repeat (4) cyc(S_HALT, 7'b0, 1'b0);
        resume    = 1'b0;
        imem_busy = 1'b0;
        do_reset();
        instr(0, 0, 0, 0, 0);
        cyc(S_IF, 7'b0, 1'b1);
        cyc(S_IFW, 7'b0, 1'b1);
        cyc(S_IFW, 7'b0100000, 1'b1);
        cyc(S_ID, 7'b0010000, 1'b1);
        scb.push_back(mk(S_EX, 7'b0001000, 1'b1));
        base = pc_cnt;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        exp_ret = '0;
        #1;
        scb.push_back(mk(S_INIT, 7'b0, 1'b0));
        ->probe;
        @(posedge clk);
        #1;
        cyc(S_INIT, 7'b0, 1'b0);
        reset_n = 1'b1;
        cyc(S_INIT, 7'b0, 1'b0);
        cyc(S_IF, 7'b0, 1'b1);
        chk("no_pc_after_abort", pc_cnt - base, 0);
        for (int i = 0; i < 10 && scb.size() > 0; i++)
            @(negedge clk);
        #1;
        chk("scoreboard_drained", scb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
